// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache with zero-latency hit path and blocking line refill.
// Define ICACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module icache_fetch #(
  parameter int unsigned NUM_LINES  = 8,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IR_addr,
  output logic [31:0] IR,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
`ifdef ICACHE_STATS_EN
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt,
`endif
  input  logic        mem_ready
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic {StIdle, StRefill} state_e;

  state_e                  r_state;
  logic [NUM_LINES-1:0]    r_valid;
  logic [TAG_W-1:0]        r_tag  [NUM_LINES];
  logic [31:0]             r_data [NUM_LINES*LINE_WORDS];
  logic                    r_mem_req;
  // Refill address doubles as the latched tag/index and the word counter.
  logic [31:0]             r_mem_addr;

  logic [IDX_W-1:0]        w_idx;
  logic [TAG_W-1:0]        w_tag;
  logic [IDX_W+OFF_W-1:0]  w_rd_ptr;
  logic [IDX_W-1:0]        w_ref_idx;
  logic [TAG_W-1:0]        w_ref_tag;
  logic [IDX_W+OFF_W-1:0]  w_fill_ptr;
  logic [OFF_W-1:0]        w_cnt;
  logic                    w_last;
  logic                    w_hit;
  logic [1:0]              w_unused_addr;

  assign w_idx         = IR_addr[IDX_W+OFF_W+1:OFF_W+2];
  assign w_tag         = IR_addr[31:IDX_W+OFF_W+2];
  assign w_rd_ptr      = IR_addr[IDX_W+OFF_W+1:2];
  assign w_unused_addr = IR_addr[1:0];

  assign w_ref_idx  = r_mem_addr[IDX_W+OFF_W+1:OFF_W+2];
  assign w_ref_tag  = r_mem_addr[31:IDX_W+OFF_W+2];
  assign w_fill_ptr = r_mem_addr[IDX_W+OFF_W+1:2];
  assign w_cnt      = r_mem_addr[OFF_W+1:2];
  assign w_last     = (w_cnt == OFF_W'(LINE_WORDS - 1));

  assign w_hit    = (r_state == StIdle) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign IR       = w_hit ? r_data[w_rd_ptr] : 32'h0000_0000;
  assign stall    = ~w_hit;
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_valid    <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (!w_hit) begin
            r_state        <= StRefill;
            r_mem_req      <= 1'b1;
            r_mem_addr     <= {IR_addr[31:OFF_W+2], {OFF_W{1'b0}}, 2'b00};
            r_valid[w_idx] <= 1'b0;
          end
        end
        StRefill: begin
          if (mem_ready) begin
            if (w_last) begin
              r_state            <= StIdle;
              r_mem_req          <= 1'b0;
              r_mem_addr         <= '0;
              r_valid[w_ref_idx] <= 1'b1;
            end else begin
              r_mem_addr <= r_mem_addr + 32'd4;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Arrays carry no reset; a line only becomes visible once its valid bit is set.
  always_ff @(posedge clk) begin
    if (rst_n && (r_state == StRefill) && mem_ready) begin
      r_data[w_fill_ptr] <= mem_rdata;
      if (w_last) begin
        r_tag[w_ref_idx] <= w_ref_tag;
      end
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit && (r_hit_cnt != 16'hFFFF)) begin
        r_hit_cnt <= r_hit_cnt + 16'd1;
      end
      if ((r_state == StIdle) && !w_hit && (r_miss_cnt != 16'hFFFF)) begin
        r_miss_cnt <= r_miss_cnt + 16'd1;
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Scoreboard bench for icache_fetch; expected instruction words are queued per fetch.
// Memory model returns 0x1000_0000 + word address.
module tb_icache_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] IR_addr;
  logic [31:0] IR;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] sb_q[$];
  logic [31:0] addr_log[$];
  bit          toggle_ready = 1'b0;
  int          stalls;

  icache_fetch #(
    .NUM_LINES (8),
    .LINE_WORDS(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .IR_addr  (IR_addr),
    .IR       (IR),
    .stall    (stall),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
`ifdef ICACHE_STATS_EN
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
`endif
    .mem_ready(mem_ready)
  );

  assign mem_rdata = 32'h1000_0000 + {2'b00, mem_addr[31:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present addr until the DUT stops stalling; returns the stall cycle count.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp, input string tag,
                       output int n_stall);
    logic [31:0] held;
    bit          hold_pend;
    bit          done;
    IR_addr = addr;
    sb_q.push_back(exp);
    addr_log.delete();
    n_stall   = 0;
    hold_pend = 1'b0;
    done      = 1'b0;
    held      = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      mem_ready = toggle_ready ? (c % 2 == 1) : 1'b1;
      #1;
      if (hold_pend) check({tag, "_hold"}, mem_addr, held);
      hold_pend = 1'b0;
      if (!stall) begin
        check({tag, "_ir"}, IR, sb_q.pop_front());
        check({tag, "_req"}, {31'd0, mem_req}, 32'd0);
        done = 1'b1;
      end else begin
        n_stall++;
        check({tag, "_nop"}, IR, 32'd0);
        if (mem_req && mem_ready) addr_log.push_back(mem_addr);
        if (mem_req && !mem_ready) begin
          held      = mem_addr;
          hold_pend = 1'b1;
        end
      end
      next_cycle();
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    if (!done) void'(sb_q.pop_front());
    mem_ready = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    IR_addr   = 32'h0;
    mem_ready = 1'b1;
    repeat (2) next_cycle();
    #1;
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd1);
    check("rst_ir", IR, 32'd0);
    rst_n = 1'b1;

    // Cold fetch: word 0 after five stall cycles, refill addresses 0x0..0xC.
    fetch(32'h0, 32'h1000_0000, "cold", stalls);
    check("cold_stalls", 32'(stalls), 32'd5);
    check("cold_nreq", 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("cold_maddr", addr_log[i], 32'(4 * i));

    for (int i = 1; i < 4; i++) begin
      fetch(32'(4 * i), 32'h1000_0000 + 32'(i), "hit", stalls);
      check("hit_stalls", 32'(stalls), 32'd0);
    end
`ifdef ICACHE_STATS_EN
    check("miss_cnt", {16'd0, miss_cnt}, 32'd1);
    check("hit_cnt", {16'd0, hit_cnt}, 32'd4);
`endif

    // Second line, then a conflict on line 0 that must leave line 1 alone.
    fetch(32'h10, 32'h1000_0004, "line1", stalls);
    check("line1_stalls", 32'(stalls), 32'd5);
    fetch(32'h80, 32'h1000_0020, "conf", stalls);
    check("conf_stalls", 32'(stalls), 32'd5);
    for (int i = 0; i < 4; i++) check("conf_maddr", addr_log[i], 32'h80 + 32'(4 * i));
    fetch(32'h0, 32'h1000_0000, "refetch", stalls);
    check("refetch_stalls", 32'(stalls), 32'd5);
    fetch(32'h14, 32'h1000_0005, "keep1", stalls);
    check("keep1_stalls", 32'(stalls), 32'd0);

    // Address moves mid-refill: refill of 0x100 continues, new address served afterwards.
    IR_addr = 32'h100;
    #1;
    check("mv_miss", {31'd0, stall}, 32'd1);
    next_cycle();
    IR_addr = 32'h14;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("mv_stall", {31'd0, stall}, 32'd1);
      check("mv_maddr", mem_addr, 32'h100 + 32'(4 * i));
      next_cycle();
    end
    #1;
    check("mv_new_stall", {31'd0, stall}, 32'd0);
    check("mv_new_ir", IR, 32'h1000_0005);
    next_cycle();
    fetch(32'h100, 32'h1000_0040, "mv_old", stalls);
    check("mv_old_stalls", 32'(stalls), 32'd0);

    // Handshake throttled every other cycle.
    toggle_ready = 1'b1;
    fetch(32'h40, 32'h1000_0010, "slow", stalls);
    toggle_ready = 1'b0;
    check("slow_stalls", 32'(stalls), 32'd8);
    for (int i = 0; i < 4; i++) check("slow_maddr", addr_log[i], 32'h40 + 32'(4 * i));
    for (int i = 1; i < 4; i++) begin
      fetch(32'h40 + 32'(4 * i), 32'h1000_0010 + 32'(i), "slow_hit", stalls);
      check("slow_hit_stalls", 32'(stalls), 32'd0);
    end

    // Reset in the second refill cycle aborts; the line refills from word 0.
    IR_addr = 32'h20;
    #1;
    next_cycle();
    next_cycle();
    rst_n = 1'b0;
    #1;
    check("abort_req_pre", {31'd0, mem_req}, 32'd1);
    next_cycle();
    rst_n = 1'b1;
    #1;
    check("abort_req", {31'd0, mem_req}, 32'd0);
    check("abort_addr", mem_addr, 32'd0);
    check("abort_stall", {31'd0, stall}, 32'd1);
    fetch(32'h20, 32'h1000_0008, "abort_re", stalls);
    check("abort_stalls", 32'(stalls), 32'd5);
    check("abort_first", addr_log[0], 32'h20);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
ICACHE_FETCH -- requirements
Module: icache_fetch

Interface
REQ-001 The block SHALL have parameter NUM_LINES, default 8, number of direct-mapped lines (power of two, 2..64).
REQ-002 The block SHALL have parameter LINE_WORDS, default 4, 32-bit words per line (power of two, 2..8).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 IR_addr  in  32  byte fetch address from core PC; bits [1:0] ignored.
REQ-006 IR  out  32  instruction for IR_addr.
REQ-007 stall  out  1  high while IR is not valid for current IR_addr.
REQ-008 mem_req  out  1  refill read request to backing instruction memory.
REQ-009 mem_addr  out  32  word-aligned refill address.
REQ-010 mem_rdata  in  32  refill data, valid when mem_ready high.
REQ-011 mem_ready  in  1  memory accepts mem_addr and returns mem_rdata in the same cycle.

Function
REQ-012 Address split SHALL be offset = IR_addr[log2(LINE_WORDS)+1:2], index = next log2(NUM_LINES) bits, tag = remaining upper bits.
REQ-013 Hit = valid[index] and stored tag equal to tag, evaluated combinationally while in IDLE.
REQ-014 On hit, IR SHALL equal the stored word for index/offset and stall SHALL be 0 in the same cycle (zero-latency).
REQ-015 While stall is 1, IR SHALL be 32'h0000_0000 (MIPS nop).
REQ-016 FSM states SHALL be IDLE and REFILL only.
REQ-017 IDLE -> REFILL on a rising edge where hit is 0; tag and index of IR_addr latched at that edge; word counter cleared.
REQ-018 In REFILL, mem_req SHALL be 1 and mem_addr SHALL be {latched tag, latched index, counter, 2'b00}, held stable until mem_ready.
REQ-019 Each REFILL cycle with mem_ready = 1 SHALL write mem_rdata into the line at word counter and increment counter.
REQ-020 On the mem_ready cycle of the last word, the line's tag SHALL be written, valid set, and the FSM SHALL return to IDLE.
REQ-021 With mem_ready tied high, a miss SHALL stall exactly LINE_WORDS+1 cycles; hit on the following cycle.
REQ-022 stall SHALL be 1 in REFILL irrespective of IR_addr.
REQ-023 IR_addr changes during REFILL SHALL NOT alter the refill in progress; the new address is looked up on return to IDLE.
REQ-024 mem_ready while mem_req = 0 SHALL be ignored.
REQ-025 A refill to a valid line SHALL overwrite it; no other line is affected.

Reset
REQ-026 With rst_n = 0 at a rising edge: state IDLE, all valid bits 0, counter 0; tag/data arrays need no reset.
REQ-027 During and after reset: mem_req = 0, mem_addr = 0, stall = 1 (reset IDLE misses), IR = 0.
REQ-028 Reset during REFILL SHALL abort it and leave the partially filled line invalid.

Configuration
REQ-029 Macro ICACHE_STATS_EN defined: outputs hit_cnt[15:0] and miss_cnt[15:0] exist; hit_cnt increments each IDLE cycle with a hit, miss_cnt on each IDLE->REFILL transition; both saturate at 16'hFFFF and clear on reset.
REQ-030 Macro ICACHE_STATS_EN undefined: those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-031 Cold fetch IR_addr=0x0, mem_ready=1, memory word n = 0x1000_0000+n -> mem_addr 0x0,0x4,0x8,0xC on cycles 1-4; stall 1 for 5 cycles; IR=0x1000_0000 cycle 5.
REQ-032 After REQ-031, IR_addr=0x4,0x8,0xC -> stall 0, IR 0x1000_0001..0x1000_0003, mem_req 0.
REQ-033 Conflict: IR_addr=0x80 (same index, new tag) -> refill 0x80..0x8C; re-fetch 0x0 -> misses again.
REQ-034 mem_ready toggled 1,0,1,0... during refill -> mem_addr held during low cycles; refill completes after 8 cycles; data correct.
REQ-035 rst_n=0 in the 2nd REFILL cycle, released -> mem_req 0, same address misses and refills from word 0.
REQ-036 With ICACHE_STATS_EN: sequence of REQ-031/032 -> miss_cnt=1, hit_cnt=4.
